// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton scanner: per-channel state encoding
// and the counter-width helper used by every channel.
package btn_pkg;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] DEB_PRESS   = 3'd1;
  localparam logic [2:0] PRESSED     = 3'd2;
  localparam logic [2:0] LONG_HELD   = 3'd3;
  localparam logic [2:0] DEB_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE        = IDLE,
    ST_DEB_PRESS   = DEB_PRESS,
    ST_PRESSED     = PRESSED,
    ST_LONG_HELD   = LONG_HELD,
    ST_DEB_RELEASE = DEB_RELEASE
  } btn_state_e;

  // One counter serves both the debounce and the long-hold phases.
  function automatic int cnt_w(input int deb_ticks, input int long_ticks);
    int m;
    m = (deb_ticks > long_ticks) ? deb_ticks : long_ticks;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton: two-flop synchronizer, debounce/long-hold FSM and
// registered level, press, release and long-press outputs.
module btn_channel import btn_pkg::*; #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 3000,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int            CW        = cnt_w(DEBOUNCE_TICKS, LONG_TICKS);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic          INACTIVE  = ACTIVE_LOW;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_flag_q, long_flag_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          p;

  assign p = sync2_q ^ INACTIVE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= INACTIVE;
      sync2_q     <= INACTIVE;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (p) begin
          state_d = ST_DEB_PRESS;
          cnt_d   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!p) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PRESSED: begin
        if (!p) begin
          state_d = ST_DEB_RELEASE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == LONG_LAST) begin
            state_d     = ST_LONG_HELD;
            cnt_d       = '0;
            long_d      = 1'b1;
            long_flag_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LONG_HELD: begin
        if (!p) begin
          state_d = ST_DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_DEB_RELEASE: begin
        // A bounce back to pressed restarts the hold time from zero.
        if (p) begin
          state_d = long_flag_q ? ST_LONG_HELD : ST_PRESSED;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == DEB_LAST) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            release_d   = 1'b1;
            level_d     = 1'b0;
            long_flag_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/button_scanner.sv
// Pushbutton front end: shared slow debounce tick plus one independent
// debounce/classify channel per board button.
module button_scanner #(
  parameter int NUM_BTN        = 4,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 3000,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic               tick
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  // tick_q is registered from the next count so it is high exactly while
  // the count sits at TICK_DIV-1.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick_q),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_scanner.sv
// Directed bench for button_scanner with a short tick and small debounce
// and long-hold limits so every event path fits in a few hundred clocks.
module tb_button_scanner;

  localparam int NUM_BTN        = 4;
  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int LONG_TICKS     = 10;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_BTN-1:0] btn_raw = '1;
  logic [NUM_BTN-1:0] btn_level, press_pulse, release_pulse, long_pulse;
  logic               tick;

  always #5 clk = ~clk;

  button_scanner #(
    .NUM_BTN        (NUM_BTN),
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .LONG_TICKS     (LONG_TICKS),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .tick          (tick)
  );

  // Rising edges since the last edge that sampled rst high.
  int n = 0;
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // ---------------- event log (sampled 1 time unit after each edge) --------
  int         press_cnt[NUM_BTN], release_cnt[NUM_BTN], long_cnt[NUM_BTN];
  int         press_edge[NUM_BTN], release_edge[NUM_BTN], long_edge[NUM_BTN];
  int         tick_cnt, tick_first, press_evt_cnt, overlap_cnt;
  logic [3:0] press_vec;

  always @(posedge clk) begin
    #1;
    if (tick) begin
      if (tick_cnt == 0) tick_first = n;
      tick_cnt++;
    end
    if (press_pulse != '0) begin
      press_evt_cnt++;
      press_vec = press_pulse;
    end
    if (((press_pulse & release_pulse) | (long_pulse & (press_pulse | release_pulse))) != '0)
      overlap_cnt++;
    for (int ch = 0; ch < NUM_BTN; ch++) begin
      if (press_pulse[ch])   begin press_cnt[ch]++;   press_edge[ch]   = n; end
      if (release_pulse[ch]) begin release_cnt[ch]++; release_edge[ch] = n; end
      if (long_pulse[ch])    begin long_cnt[ch]++;    long_edge[ch]    = n; end
    end
  end

  task automatic clear_log();
    for (int ch = 0; ch < NUM_BTN; ch++) begin
      press_cnt[ch]    = 0;
      release_cnt[ch]  = 0;
      long_cnt[ch]     = 0;
      press_edge[ch]   = -1;
      release_edge[ch] = -1;
      long_edge[ch]    = -1;
    end
    tick_cnt      = 0;
    tick_first    = -1;
    press_evt_cnt = 0;
    press_vec     = '0;
  endtask

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // The channel FSM enters DEB_PRESS/DEB_RELEASE two edges after the
  // synchronizer first samples the new level at edge a; from the next edge on
  // it counts every edge that samples tick high, i.e. every edge index that
  // is a multiple of TICK_DIV. Returns the edge of the k-th counted tick.
  function automatic int tick_edge(input int a, input int k);
    int e;
    int seen;
    e    = a + 2;
    seen = 0;
    while (seen < k) begin
      e++;
      if (e % TICK_DIV == 0) seen++;
    end
    return e;
  endfunction

  task automatic wait_until(input int target);
    while (n < target) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int pe, le, re;
    overlap_cnt = 0;
    clear_log();

    // Reset state
    rst     = 1'b1;
    btn_raw = 4'b1111;
    repeat (5) @(negedge clk);
    check_eq("rst_level",   btn_level,     0);
    check_eq("rst_press",   press_pulse,   0);
    check_eq("rst_release", release_pulse, 0);
    check_eq("rst_long",    long_pulse,    0);
    check_eq("rst_tick",    tick,          0);
    clear_log();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("tick_first", tick_first, 3);
    check_eq("tick_count", tick_cnt,   2);

    // Clean press on channel 0
    clear_log();
    pe = tick_edge(n + 1, DEBOUNCE_TICKS);
    btn_raw[0] = 1'b0;
    wait_until(pe + 4);
    check_eq("press0_count",  press_cnt[0],  1);
    check_eq("press0_edge",   press_edge[0], pe);
    check_eq("press0_level",  btn_level,     4'b0001);
    check_eq("press0_others", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Clean release on channel 0
    clear_log();
    re = tick_edge(n + 1, DEBOUNCE_TICKS);
    btn_raw[0] = 1'b1;
    wait_until(re + 4);
    check_eq("release0_count", release_cnt[0],  1);
    check_eq("release0_edge",  release_edge[0], re);
    check_eq("release0_level", btn_level,       4'b0000);
    check_eq("release0_nolong", long_cnt[0],    0);

    // Bounce on channel 1: 3-clk runs never span three ticks
    clear_log();
    for (int i = 0; i < 40; i++) begin
      btn_raw[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    btn_raw[1] = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("bounce1_press",   press_cnt[1],   0);
    check_eq("bounce1_release", release_cnt[1], 0);
    check_eq("bounce1_level",   btn_level[1],   0);

    // Long press on channel 2
    clear_log();
    pe = tick_edge(n + 1, DEBOUNCE_TICKS);
    le = pe + LONG_TICKS * TICK_DIV;
    btn_raw[2] = 1'b0;
    wait_until(le + 20);
    check_eq("long2_press_edge", press_edge[2], pe);
    check_eq("long2_press_cnt",  press_cnt[2],  1);
    check_eq("long2_edge",       long_edge[2],  le);
    check_eq("long2_once",       long_cnt[2],   1);
    check_eq("long2_level",      btn_level,     4'b0100);
    re = tick_edge(n + 1, DEBOUNCE_TICKS);
    btn_raw[2] = 1'b1;
    wait_until(re + 4);
    check_eq("long2_release_edge", release_edge[2], re);
    check_eq("long2_release_cnt",  release_cnt[2],  1);
    check_eq("long2_release_lvl",  btn_level,       4'b0000);
    check_eq("long2_no_relong",    long_cnt[2],     1);

    // Simultaneous press on channels 0 and 3
    clear_log();
    pe = tick_edge(n + 1, DEBOUNCE_TICKS);
    btn_raw = 4'b0110;
    wait_until(pe + 2);
    check_eq("sim_press_events", press_evt_cnt, 1);
    check_eq("sim_press_vec",    press_vec,     4'b1001);
    check_eq("sim_edge0",        press_edge[0], pe);
    check_eq("sim_edge3",        press_edge[3], pe);
    check_eq("sim_level",        btn_level,     4'b1001);

    // Reset while both are held
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 0);
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 0);
    pe = tick_edge(1, DEBOUNCE_TICKS);
    wait_until(pe + 2);
    check_eq("repress_events", press_evt_cnt, 1);
    check_eq("repress_vec",    press_vec,     4'b1001);
    check_eq("repress_edge",   press_edge[0], pe);
    check_eq("repress_level",  btn_level,     4'b1001);
    check_eq("repress_nolong", long_cnt[0] + long_cnt[3], 0);

    // Release both and confirm the global exclusivity of pulses
    btn_raw = 4'b1111;
    repeat (30) @(negedge clk);
    check_eq("final_release", release_cnt[0] + release_cnt[3], 2);
    check_eq("final_level",   btn_level, 0);
    check_eq("pulse_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
